// File: rtl/adc_spi_reader_if.sv
// adc_spi_reader_if: bundles the ADC pins and the sample output bus of the
// SPI ADC reader.
//   master - the reader:   drives adc_cs_n/adc_sclk/adc_din, sample,
//                          sample_valid, sample_channel, busy;
//                          takes enable, channel, adc_dout.
//   slave  - the other side (ADC pins plus the downstream consumer).
interface adc_spi_reader_if;
    logic        enable;
    logic [2:0]  channel;
    logic        adc_dout;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_din;
    logic [11:0] sample;
    logic        sample_valid;
    logic [2:0]  sample_channel;
    logic        busy;

    modport master (
        input  enable, channel, adc_dout,
        output adc_cs_n, adc_sclk, adc_din,
        output sample, sample_valid, sample_channel, busy
    );

    modport slave (
        output enable, channel, adc_dout,
        input  adc_cs_n, adc_sclk, adc_din,
        input  sample, sample_valid, sample_channel, busy
    );
endinterface

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: continuous-conversion driver for an 8-channel 12-bit SPI
// ADC (SCLK idles high). Each frame sends the channel address on adc_din,
// shifts 16 bits in from adc_dout and publishes the low 12 bits as `sample`
// with a one-cycle sample_valid strobe.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - adc_spi_reader_if.master (enable, channel, ADC pins, sample bus)
// Parameters:
//   CLK_DIV   - clk cycles per SCLK half-period (one tick), >= 2
//   GAP_TICKS - ticks of CS_n high between frames, >= 1
module adc_spi_reader #(
    parameter int CLK_DIV   = 25,
    parameter int GAP_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    adc_spi_reader_if.master bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div, div_n;
    logic [3:0]    k, k_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic [15:0]   shift, shift_n;
    logic [2:0]    ch_reg, ch_reg_n;
    logic          cs_n, cs_n_n;
    logic          sclk, sclk_n;
    logic          din, din_n;
    logic [11:0]   sample, sample_n;
    logic          sample_valid, sample_valid_n;
    logic [2:0]    sample_ch, sample_ch_n;
    logic          tick;
    logic          start;
    logic [15:0]   cmd;

    assign tick = (div == DIV_LAST);
    assign cmd  = {2'b00, ch_reg, 11'b0};

    always_comb begin
        state_n        = state;
        div_n          = '0;
        k_n            = k;
        gap_cnt_n      = gap_cnt;
        shift_n        = shift;
        ch_reg_n       = ch_reg;
        cs_n_n         = cs_n;
        sclk_n         = sclk;
        din_n          = din;
        sample_n       = sample;
        sample_valid_n = 1'b0;
        sample_ch_n    = sample_ch;
        start          = 1'b0;

        case (state)
            IDLE: begin
                cs_n_n = 1'b1;
                sclk_n = 1'b1;
                din_n  = 1'b0;
                start  = bus.enable;
            end
            FRAME: begin
                div_n = tick ? '0 : div + 1'b1;
                if (tick) begin
                    if (sclk) begin
                        // Falling edge: present command bit k, ADC latches it on the next rise.
                        sclk_n = 1'b0;
                        din_n  = cmd[4'd15 - k];
                    end else begin
                        sclk_n  = 1'b1;
                        shift_n = {shift[14:0], bus.adc_dout};
                        k_n     = k + 4'd1;
                        if (k == 4'd15) begin
                            // Top 4 bits are the ADC's leading zeros; not checked.
                            state_n        = GAP;
                            cs_n_n         = 1'b1;
                            din_n          = 1'b0;
                            gap_cnt_n      = '0;
                            sample_n       = shift_n[11:0];
                            sample_ch_n    = ch_reg;
                            sample_valid_n = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                cs_n_n = 1'b1;
                sclk_n = 1'b1;
                din_n  = 1'b0;
                div_n  = tick ? '0 : div + 1'b1;
                if (tick) begin
                    if (gap_cnt == GAP_LAST) begin
                        if (bus.enable) start   = 1'b1;
                        else            state_n = IDLE;
                    end else begin
                        gap_cnt_n = gap_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Frame entry, shared by IDLE and GAP.
        if (start) begin
            state_n  = FRAME;
            cs_n_n   = 1'b0;
            sclk_n   = 1'b1;
            ch_reg_n = bus.channel;
            din_n    = 1'b0;  // cmd[15] is always 0
            k_n      = 4'd0;
            div_n    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div          <= '0;
            k            <= 4'd0;
            gap_cnt      <= '0;
            shift        <= 16'd0;
            ch_reg       <= 3'd0;
            cs_n         <= 1'b1;
            sclk         <= 1'b1;
            din          <= 1'b0;
            sample       <= 12'd0;
            sample_valid <= 1'b0;
            sample_ch    <= 3'd0;
        end else begin
            state        <= state_n;
            div          <= div_n;
            k            <= k_n;
            gap_cnt      <= gap_cnt_n;
            shift        <= shift_n;
            ch_reg       <= ch_reg_n;
            cs_n         <= cs_n_n;
            sclk         <= sclk_n;
            din          <= din_n;
            sample       <= sample_n;
            sample_valid <= sample_valid_n;
            sample_ch    <= sample_ch_n;
        end
    end

    assign bus.adc_cs_n       = cs_n;
    assign bus.adc_sclk       = sclk;
    assign bus.adc_din        = din;
    assign bus.sample         = sample;
    assign bus.sample_valid   = sample_valid;
    assign bus.sample_channel = sample_ch;
    assign bus.busy           = (state != IDLE);
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: ADC model plus scoreboard for adc_spi_reader.
// The model picks a 16-bit word per frame when CS_n falls, shifts it out MSB
// first on SCLK falling edges, records DIN on SCLK rising edges, and pushes
// the expected sample/channel; sample_valid pops and compares.
module tb_adc_spi_reader;
    localparam int CLK_DIV   = 3;
    localparam int GAP_TICKS = 2;
    localparam int FRAME_CYC = 32 * CLK_DIV;
    localparam int PERIOD    = (32 + GAP_TICKS) * CLK_DIV;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_spi_reader_if bus ();

    adc_spi_reader #(.CLK_DIV(CLK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [11:0] smp;
        logic [2:0]  ch;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, cs_falls = 0, vcount = 0;
    int          fall_cyc = 0, rise_cyc = 0, last_vcyc = 0, rises = 0, bitn = 0;
    logic        have_rise = 1'b0, have_prev = 1'b0, cont = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;
    logic [15:0] cur_word = 16'd0, din_word = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Word the ADC returns in frame number i (counted over the whole run).
    function automatic logic [15:0] word_for(input int i);
        case (i)
            0:       return 16'h0A5C;
            1:       return 16'h0FFF;
            2:       return 16'h0000;
            3:       return 16'hF123;  // junk in the leading nibble
            4:       return 16'h0555;
            5:       return 16'h0111;
            6:       return 16'h0222;
            7:       return 16'h0ABC;  // killed by reset
            8:       return 16'h5DEF;
            default: return 16'h0000;
        endcase
    endfunction

    // ADC model + monitor + scoreboard.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            bus.adc_dout = 1'b0;
        end
        if (prev_cs && !bus.adc_cs_n) begin
            cur_word = word_for(cs_falls);
            cs_falls++;
            bitn     = 15;
            rises    = 0;
            din_word = 16'd0;
            fall_cyc = cyc;
            exp_q.push_back('{cur_word[11:0], bus.channel});
            if (cont && have_rise) chk("gap_len", cyc - rise_cyc, GAP_TICKS * CLK_DIV);
        end
        if (!prev_cs && bus.adc_cs_n) begin
            rise_cyc  = cyc;
            have_rise = 1'b1;
        end
        if (!prev_sclk && bus.adc_sclk && !prev_cs) begin
            din_word = {din_word[14:0], bus.adc_din};
            rises++;
        end
        if (prev_sclk && !bus.adc_sclk && !bus.adc_cs_n) begin
            bus.adc_dout = (bitn >= 0) ? cur_word[4'(bitn)] : 1'b0;
            bitn--;
        end
        if (bus.sample_valid) begin
            chk("valid_width", 32'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sample", 32'(bus.sample), 32'(e.smp));
                chk("sample_channel", 32'(bus.sample_channel), 32'(e.ch));
                chk("din_cmd", 32'(din_word), 32'({2'b00, e.ch, 11'b0}));
            end
            chk("sclk_rises", rises, 16);
            chk("valid_latency", cyc - fall_cyc, FRAME_CYC);
            if (cont && have_prev) chk("valid_period", cyc - last_vcyc, PERIOD);
            last_vcyc = cyc;
            have_prev = 1'b1;
            vcount++;
        end
        if (!cont) begin
            have_rise = 1'b0;
            have_prev = 1'b0;
        end
        prev_cs    = bus.adc_cs_n;
        prev_sclk  = bus.adc_sclk;
        prev_valid = bus.sample_valid;
    end

    task automatic wait_falls(input int n);
        int t = 0;
        while (cs_falls < n && t < 3000) begin @(negedge clk); t++; end
        chk("wait_cs_fall", 32'(cs_falls >= n), 1);
    endtask

    task automatic wait_valids(input int n);
        int t = 0;
        while (vcount < n && t < 3000) begin @(negedge clk); t++; end
        chk("wait_valid", 32'(vcount >= n), 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.busy && t < 300) begin @(negedge clk); t++; end
        chk("wait_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.enable  = 1'b0;
        bus.channel = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(bus.adc_cs_n), 1);
        chk("rst_sclk", 32'(bus.adc_sclk), 1);
        chk("rst_din", 32'(bus.adc_din), 0);
        chk("rst_sample", 32'(bus.sample), 0);
        chk("rst_valid", 32'(bus.sample_valid), 0);
        chk("rst_channel", 32'(bus.sample_channel), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;

        // Single frame, channel 5, data 0xA5C.
        @(negedge clk);
        bus.channel = 3'd5;
        bus.enable  = 1'b1;
        wait_falls(1);
        bus.enable = 1'b0;
        wait_valids(1);
        wait_idle();
        repeat (300) @(negedge clk);
        chk("no_restart_1", cs_falls, 1);
        chk("idle_cs_n", 32'(bus.adc_cs_n), 1);

        // Continuous burst: 0xFFF, 0x000, 0xF123, then enable drops at tick 20 of frame 4.
        bus.channel = 3'd3;
        cont        = 1'b1;
        bus.enable  = 1'b1;
        wait_falls(5);
        repeat (20 * CLK_DIV) @(negedge clk);
        bus.enable = 1'b0;
        wait_valids(5);
        cont = 1'b0;
        wait_idle();
        repeat (300) @(negedge clk);
        chk("no_restart_2", cs_falls, 5);

        // Channel 2 -> 7 at tick 5 of a frame; takes effect next frame.
        bus.channel = 3'd2;
        bus.enable  = 1'b1;
        wait_falls(6);
        repeat (5 * CLK_DIV) @(negedge clk);
        bus.channel = 3'd7;
        wait_falls(7);
        bus.enable = 1'b0;
        wait_valids(7);
        wait_idle();

        // Reset around tick 10 of a frame, enable held high throughout.
        bus.channel = 3'd4;
        bus.enable  = 1'b1;
        wait_falls(8);
        repeat (9 * CLK_DIV + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs_n", 32'(bus.adc_cs_n), 1);
        chk("mid_rst_sclk", 32'(bus.adc_sclk), 1);
        chk("mid_rst_din", 32'(bus.adc_din), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_valid", 32'(bus.sample_valid), 0);
        chk("mid_rst_sample", 32'(bus.sample), 0);
        chk("mid_rst_channel", 32'(bus.sample_channel), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_falls(9);
        bus.enable = 1'b0;
        wait_valids(8);
        wait_idle();
        chk("valid_count", vcount, 8);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
